perip_bridge: RTL and testbench

Memory-mapped responder on the CPU's peripheral data bus. It decodes every access issued on `perip_addr`, `perip_wen`, `perip_mask` and `perip_wdata`. It then serves the access from a word-organised data RAM or from a small MMIO register file: switches, keys, LEDs, 7-segment value and a millisecond counter. It returns read data on `perip_rdata` with a fixed one-cycle latency. It sits between the core's LSU port and the board I/O.

---
 rtl/perip_bridge_if.sv | 25 ++
 rtl/perip_bridge.sv | 168 ++++++++++++++++
 tb/tb_perip_bridge.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/perip_bridge_if.sv
// Peripheral data bus between the core's LSU port and the peripheral bridge.
// The master drives address/control/write data; the slave returns registered read data.
interface perip_bridge_if;
    logic [31:0] perip_addr;
    logic        perip_wen;
    logic [1:0]  perip_mask;
    logic [31:0] perip_wdata;
    logic [31:0] perip_rdata;

    modport master (
        output perip_addr,
        output perip_wen,
        output perip_mask,
        output perip_wdata,
        input  perip_rdata
    );

    modport slave (
        input  perip_addr,
        input  perip_wen,
        input  perip_mask,
        input  perip_wdata,
        output perip_rdata
    );
endinterface

// File: rtl/perip_bridge.sv
// Peripheral bus responder: word-organised data RAM plus MMIO switches, keys, LEDs,
// 7-segment value and a millisecond counter, with one-cycle registered read data.
module perip_bridge #(
    parameter int DRAM_AW    = 16,
    parameter int CLK_PER_MS = 50000
) (
    input  logic                 cpu_clk,
    input  logic                 cpu_rst,
    perip_bridge_if.slave        bus,
    input  logic [31:0]          sw_in,
    input  logic [7:0]           key_in,
    output logic [31:0]          led_out,
    output logic [31:0]          seg_out
);

    localparam logic [32:0] DRAM_BASE  = 33'h0_8010_0000;
    localparam logic [32:0] DRAM_LIMIT = DRAM_BASE + (33'd1 << (DRAM_AW + 2));
    localparam logic [31:0] SW_ADDR    = 32'h8020_0000;
    localparam logic [31:0] KEY_ADDR   = 32'h8020_0010;
    localparam logic [31:0] SEG_ADDR   = 32'h8020_0020;
    localparam logic [31:0] LED_ADDR   = 32'h8020_0040;
    localparam logic [31:0] CNT_ADDR   = 32'h8020_0050;
    localparam logic [31:0] CNT_START  = 32'h8000_0000;
    localparam logic [31:0] CNT_STOP   = 32'hFFFF_FFFF;

    localparam int PRESC_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_PER_MS - 1);

    typedef enum logic {
        CNT_IDLE = 1'b0,
        CNT_RUN  = 1'b1
    } cnt_state_e;

    // ---------------------------------------------------------------- decode
    logic               dram_hit;
    logic [DRAM_AW-1:0] dram_idx;
    logic [3:0]         dram_be;
    logic [31:0]        dram_wdata;
    logic               seg_wr, led_wr, cnt_wr;

    assign dram_hit = ({1'b0, bus.perip_addr} >= DRAM_BASE) &&
                      ({1'b0, bus.perip_addr} <  DRAM_LIMIT);
    assign dram_idx = bus.perip_addr[DRAM_AW+1:2];

    // Half-word lanes shifted past lane 3 fall off the 4-bit vector instead of wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        dram_be    = 4'b1111;
        dram_wdata = bus.perip_wdata;
        if (!bus.perip_mask[1]) begin
            dram_be    = (bus.perip_mask[0] ? 4'b0011 : 4'b0001) << bus.perip_addr[1:0];
            dram_wdata = bus.perip_wdata << {bus.perip_addr[1:0], 3'b000};
        end
    end

    assign seg_wr = bus.perip_wen && (bus.perip_addr == SEG_ADDR);
    assign led_wr = bus.perip_wen && (bus.perip_addr == LED_ADDR);
    assign cnt_wr = bus.perip_wen && (bus.perip_addr == CNT_ADDR);

    // ---------------------------------------------------------------- data RAM
    logic [31:0] mem_q [0:(2**DRAM_AW)-1];
    logic [31:0] dram_rdata_q;

    // NOTE: the RAM array and its read register have no reset so they map onto block RAM;
    // only the source select below is reset, which is what forces perip_rdata to 0.
    always_ff @(posedge cpu_clk) begin
        dram_rdata_q <= mem_q[dram_idx];
        if (!cpu_rst && bus.perip_wen && dram_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (dram_be[b]) begin
                    mem_q[dram_idx][8*b +: 8] <= dram_wdata[8*b +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------- counter FSM
    cnt_state_e          cnt_state_q, cnt_state_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [31:0]         ms_cnt_q, ms_cnt_d;

    always_comb begin
        cnt_state_d = cnt_state_q;
        presc_d     = presc_q;
        ms_cnt_d    = ms_cnt_q;
        if (cnt_state_q == CNT_RUN) begin
            if (presc_q == PRESC_MAX) begin
                presc_d  = '0;
                ms_cnt_d = ms_cnt_q + 32'd1;
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end
        // A control write overrides a tick landing in the same cycle.
        if (cnt_wr) begin
            if (bus.perip_wdata == CNT_START) begin
                cnt_state_d = CNT_RUN;
                presc_d     = '0;
                ms_cnt_d    = '0;
            end else if (bus.perip_wdata == CNT_STOP) begin
                cnt_state_d = CNT_IDLE;
                presc_d     = presc_q;
                ms_cnt_d    = ms_cnt_q;
            end
        end
    end

    // ---------------------------------------------------------------- MMIO state
    logic [31:0] sw_meta_q, sw_sync_q;
    logic [7:0]  key_meta_q, key_sync_q;
    logic [31:0] led_q, seg_q;
    logic [31:0] mmio_rdata_d, mmio_rdata_q;
    logic        rd_dram_q;

    always_comb begin
        mmio_rdata_d = '0;
        if (bus.perip_addr == SW_ADDR) begin
            mmio_rdata_d = sw_sync_q;
        end else if (bus.perip_addr == KEY_ADDR) begin
            mmio_rdata_d = {24'd0, key_sync_q};
        end else if (bus.perip_addr == SEG_ADDR) begin
            mmio_rdata_d = seg_q;
        end else if (bus.perip_addr == LED_ADDR) begin
            mmio_rdata_d = led_q;
        end else if (bus.perip_addr == CNT_ADDR) begin
            mmio_rdata_d = ms_cnt_q;
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            cnt_state_q  <= CNT_IDLE;
            presc_q      <= '0;
            ms_cnt_q     <= '0;
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
            key_meta_q   <= '0;
            key_sync_q   <= '0;
            led_q        <= '0;
            seg_q        <= '0;
            mmio_rdata_q <= '0;
            rd_dram_q    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples
            // pre-edge values, which is what makes the 2-flop synchroniser two stages deep.
            cnt_state_q  <= cnt_state_d;
            presc_q      <= presc_d;
            ms_cnt_q     <= ms_cnt_d;
            sw_meta_q    <= sw_in;
            sw_sync_q    <= sw_meta_q;
            key_meta_q   <= key_in;
            key_sync_q   <= key_meta_q;
            mmio_rdata_q <= mmio_rdata_d;
            rd_dram_q    <= dram_hit;
            if (led_wr) begin
                led_q <= bus.perip_wdata;
            end
            if (seg_wr) begin
                seg_q <= bus.perip_wdata;
            end
        end
    end

    assign bus.perip_rdata = rd_dram_q ? dram_rdata_q : mmio_rdata_q;
    assign led_out         = led_q;
    assign seg_out         = seg_q;

endmodule

// File: tb/tb_perip_bridge.sv
// Self-checking bench for perip_bridge: expected read data is queued when a bus cycle is
// driven and compared when the registered response appears one cycle later.
module tb_perip_bridge;

    localparam int          DRAM_AW    = 10;
    localparam int          CLK_PER_MS = 4;
    localparam logic [31:0] UNMAPPED   = 32'h9000_0000;
    localparam logic [31:0] CNT_A      = 32'h8020_0050;
    localparam logic [31:0] LED_A      = 32'h8020_0040;
    localparam logic [31:0] SEG_A      = 32'h8020_0020;
    localparam logic [31:0] SW_A       = 32'h8020_0000;
    localparam logic [31:0] KEY_A      = 32'h8020_0010;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic [31:0] sw_in   = '0;
    logic [7:0]  key_in  = '0;
    logic [31:0] led_out;
    logic [31:0] seg_out;

    perip_bridge_if bus ();

    perip_bridge #(
        .DRAM_AW    (DRAM_AW),
        .CLK_PER_MS (CLK_PER_MS)
    ) dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .bus     (bus),
        .sw_in   (sw_in),
        .key_in  (key_in),
        .led_out (led_out),
        .seg_out (seg_out)
    );

    always #5 cpu_clk = ~cpu_clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive at the falling edge, let the rising edge commit, then score.
    task automatic bus_cycle(input logic [31:0] addr, input logic wen, input logic [1:0] mask,
                             input logic [31:0] wdata, input logic chk, input logic [31:0] exp,
                             input string tag);
        logic [31:0] e;
        string       t;
        @(negedge cpu_clk);
        bus.perip_addr  = addr;
        bus.perip_wen   = wen;
        bus.perip_mask  = mask;
        bus.perip_wdata = wdata;
        if (chk) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        @(posedge cpu_clk);
        #1;
        if (chk) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, bus.perip_rdata, e);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [1:0] mask, input logic [31:0] data);
        bus_cycle(addr, 1'b1, mask, data, 1'b0, '0, "");
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        bus_cycle(addr, 1'b0, 2'b10, '0, 1'b1, exp, tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus_cycle(UNMAPPED, 1'b0, 2'b10, '0, 1'b0, '0, "");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.perip_addr  = UNMAPPED;
        bus.perip_wen   = 1'b0;
        bus.perip_mask  = 2'b10;
        bus.perip_wdata = '0;
        #1;
        check("reset_rdata", bus.perip_rdata, 32'h0);
        check("reset_led", led_out, 32'h0);
        check("reset_seg", seg_out, 32'h0);
        repeat (2) @(posedge cpu_clk);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;

        // Data RAM: word, byte, halfword, clipped halfword.
        wr(32'h8010_0004, 2'b10, 32'hDEAD_BEEF);
        rd(32'h8010_0004, 32'hDEAD_BEEF, "dram_word");
        wr(32'h8010_0006, 2'b00, 32'h0000_0011);
        wr(32'h8010_0004, 2'b01, 32'h0000_2233);
        rd(32'h8010_0004, 32'hDE11_2233, "dram_byte_half");
        wr(32'h8010_0007, 2'b01, 32'h0000_AAAA);
        rd(32'h8010_0004, 32'hAA11_2233, "dram_half_clip");

        // Mask 11 acts as a full word, addr[1:0] ignored.
        wr(32'h8010_0012, 2'b11, 32'hCAFE_BABE);
        rd(32'h8010_0010, 32'hCAFE_BABE, "dram_mask11");

        // Read during write to the same word returns the old contents.
        wr(32'h8010_0008, 2'b10, 32'h1357_9BDF);
        bus_cycle(32'h8010_0008, 1'b1, 2'b10, 32'h2468_ACE0, 1'b1, 32'h1357_9BDF, "dram_rdw_old");
        rd(32'h8010_0008, 32'h2468_ACE0, "dram_rdw_new");

        // Range boundaries: last word is mapped, one past the end is not and must not alias.
        wr(32'h8010_0000, 2'b10, 32'h1111_1111);
        wr(32'h8010_0FFC, 2'b10, 32'hFEED_F00D);
        rd(32'h8010_0FFC, 32'hFEED_F00D, "dram_last_word");
        wr(32'h8010_1000, 2'b10, 32'h0BAD_C0DE);
        rd(32'h8010_1000, 32'h0, "dram_past_end");
        rd(32'h8010_0000, 32'h1111_1111, "dram_no_alias");
        rd(32'h800F_FFFC, 32'h0, "dram_below_base");

        // LED / SEG.
        wr(LED_A, 2'b00, 32'h0000_00A5);
        check("led_out", led_out, 32'h0000_00A5);
        wr(SEG_A, 2'b00, 32'h1234_5678);
        check("seg_out", seg_out, 32'h1234_5678);
        rd(LED_A, 32'h0000_00A5, "led_readback");
        rd(SEG_A, 32'h1234_5678, "seg_readback");

        // Switches, keys, unmapped accesses.
        @(negedge cpu_clk);
        sw_in  = 32'hCAFE_0001;
        key_in = 8'h5A;
        idle(2);
        rd(SW_A, 32'hCAFE_0001, "sw_read");
        rd(KEY_A, 32'h0000_005A, "key_read");
        wr(SW_A, 2'b10, 32'h0);
        rd(SW_A, 32'hCAFE_0001, "sw_write_ignored");
        rd(UNMAPPED, 32'h0, "unmapped_read");
        wr(UNMAPPED, 2'b10, 32'hFFFF_FFFF);
        check("unmapped_wr_led", led_out, 32'h0000_00A5);
        check("unmapped_wr_seg", seg_out, 32'h1234_5678);

        // Millisecond counter with a 4-cycle prescaler.
        rd(CNT_A, 32'h0, "cnt_idle");
        wr(CNT_A, 2'b10, 32'h8000_0000);
        idle(12);
        rd(CNT_A, 32'd3, "cnt_run_3");
        wr(CNT_A, 2'b10, 32'hFFFF_FFFF);
        idle(20);
        rd(CNT_A, 32'd3, "cnt_stopped");
        wr(CNT_A, 2'b10, 32'h0000_0001);
        idle(8);
        rd(CNT_A, 32'd3, "cnt_other_ignored");
        wr(CNT_A, 2'b10, 32'h8000_0000);
        rd(CNT_A, 32'd0, "cnt_restart");
        idle(8);
        rd(CNT_A, 32'd2, "cnt_resumed");

        // Asynchronous reset mid-run with LED lit.
        wr(LED_A, 2'b10, 32'h0000_00FF);
        rd(LED_A, 32'h0000_00FF, "led_ff");
        @(negedge cpu_clk);
        #1;
        cpu_rst = 1'b1;
        #1;
        check("async_rst_rdata", bus.perip_rdata, 32'h0);
        check("async_rst_led", led_out, 32'h0);
        check("async_rst_seg", seg_out, 32'h0);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        rd(CNT_A, 32'h0, "cnt_after_rst");
        idle(10);
        rd(CNT_A, 32'h0, "cnt_stays_idle");
        rd(SW_A, 32'hCAFE_0001, "sw_resync");
        rd(32'h8010_0004, 32'hAA11_2233, "dram_kept");

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
